// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, one-entry hold buffer, redirect with in-flight drop.
// Latency: grant at N, rvalid at N+1 -> valid_o at N+2; stall_i freezes outputs, a word arriving under stall parks in the hold buffer.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   output logic        error_o
);

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_WAIT  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_DROP  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic [31:0] r_pc_out, w_pc_out_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_error, w_error_nxt;
   logic [31:0] r_hold_instr, w_hold_instr_nxt;
   logic [31:0] r_hold_pc, w_hold_pc_nxt;
   logic        r_hold_vld, w_hold_vld_nxt;
   logic        r_drop_err, w_drop_err_nxt;

   logic        w_req;
   logic        w_redir_ok;
   logic        w_outstanding;
   logic        w_slot_free;
   logic [31:0] w_pc_inc;

   // Gating with rst_n keeps the request low for the whole reset interval.
   assign w_req       = rst_n && (r_state == ST_FETCH);
   assign imem_req_o  = w_req;
   assign imem_addr_o = r_pc;
   assign instr_o     = r_instr;
   assign pc_o        = r_pc_out;
   assign valid_o     = r_valid;
   assign error_o     = r_error;

   assign w_redir_ok  = redirect_i && (redirect_pc_i[1:0] == 2'b00);
   assign w_slot_free = !r_valid || !stall_i;
   assign w_pc_inc    = r_pc + 32'd4;

   always_comb begin
      w_outstanding = 1'b0;
      case (r_state)
         ST_FETCH: w_outstanding = w_req && imem_gnt_i;
         ST_WAIT:  w_outstanding = 1'b1;
         ST_DROP:  w_outstanding = !imem_rvalid_i;
         default:  w_outstanding = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_instr_nxt      = r_instr;
      w_pc_out_nxt     = r_pc_out;
      w_valid_nxt      = r_valid;
      w_error_nxt      = r_error;
      w_hold_instr_nxt = r_hold_instr;
      w_hold_pc_nxt    = r_hold_pc;
      w_hold_vld_nxt   = r_hold_vld;
      w_drop_err_nxt   = r_drop_err;

      // Decode took the current instruction; a load below overrides this.
      if (r_valid && !stall_i) begin
         w_valid_nxt = 1'b0;
         w_instr_nxt = NOP_INSTR;
      end

      if (redirect_i) begin
         w_valid_nxt    = 1'b0;
         w_instr_nxt    = NOP_INSTR;
         w_hold_vld_nxt = 1'b0;
         if (w_redir_ok) begin
            w_pc_nxt       = redirect_pc_i;
            w_error_nxt    = 1'b0;
            w_drop_err_nxt = 1'b0;
            w_state_nxt    = w_outstanding ? ST_DROP : ST_FETCH;
         end else begin
            w_error_nxt    = 1'b1;
            w_drop_err_nxt = w_outstanding;
            w_state_nxt    = w_outstanding ? ST_DROP : ST_ERR;
         end
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_req && imem_gnt_i) begin
                  w_state_nxt = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid_i) begin
                  w_pc_nxt = w_pc_inc;
                  if (w_slot_free) begin
                     w_instr_nxt  = imem_rdata_i;
                     w_pc_out_nxt = r_pc;
                     w_valid_nxt  = 1'b1;
                     w_state_nxt  = ST_FETCH;
                  end else begin
                     w_hold_instr_nxt = imem_rdata_i;
                     w_hold_pc_nxt    = r_pc;
                     w_hold_vld_nxt   = 1'b1;
                     w_state_nxt      = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall_i) begin
                  w_instr_nxt    = r_hold_instr;
                  w_pc_out_nxt   = r_hold_pc;
                  w_valid_nxt    = 1'b1;
                  w_hold_vld_nxt = 1'b0;
                  w_state_nxt    = ST_FETCH;
               end
            end
            ST_DROP: begin
               if (imem_rvalid_i) begin
                  w_drop_err_nxt = 1'b0;
                  w_state_nxt    = r_drop_err ? ST_ERR : ST_FETCH;
               end
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= RESET_PC;
         r_instr      <= NOP_INSTR;
         r_pc_out     <= RESET_PC;
         r_valid      <= 1'b0;
         r_error      <= 1'b0;
         r_hold_instr <= NOP_INSTR;
         r_hold_pc    <= RESET_PC;
         r_hold_vld   <= 1'b0;
         r_drop_err   <= 1'b0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_instr      <= w_instr_nxt;
         r_pc_out     <= w_pc_out_nxt;
         r_valid      <= w_valid_nxt;
         r_error      <= w_error_nxt;
         r_hold_instr <= w_hold_instr_nxt;
         r_hold_pc    <= w_hold_pc_nxt;
         r_hold_vld   <= w_hold_vld_nxt;
         r_drop_err   <= w_drop_err_nxt;
      end
   end

endmodule
